// File: rtl/sb_arbiter_pkg.sv
// Shared encodings for the system-bus arbiter: access sizes, extension mode,
// FSM states and bus owner. Also holds the alignment rule used by the FSM.
// Latency: n/a (definitions only). Backpressure: n/a.
package sb_arbiter_pkg;

  // Access size carried on ls_byte_sel
  localparam logic [1:0] SB_BYTE = 2'b00;
  localparam logic [1:0] SB_HALF = 2'b01;
  localparam logic [1:0] SB_WORD = 2'b10;

  // Load extension mode carried on ls_un_sign
  localparam logic SB_SIGNED   = 1'b0;
  localparam logic SB_UNSIGNED = 1'b1;

  // Which requester owns the outstanding bus transaction
  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_LS = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } sb_state_e;

  // Halves need even addresses, words need 4-byte alignment; bytes never fault.
  // The unused size code 2'b11 is treated like a word.
  function automatic logic sb_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SB_BYTE: return 1'b0;
      SB_HALF: return off[0];
      default: return off != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/sb_lane_align.sv
// Byte-lane steering for stores and lane extraction + sign/zero extension for loads.
// Latency: purely combinational. Backpressure: none, no state.
// Ports: we_i/size_i/off_i/wdata_i -> be_o/wdata_o (store side);
//        ld_word_i/ld_off_i/ld_size_i/ld_un_sign_i -> ld_data_o (load side).
module sb_lane_align
  import sb_arbiter_pkg::*;
(
  input  logic        we_i,
  input  logic [1:0]  size_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  input  logic [31:0] ld_word_i,
  input  logic [1:0]  ld_off_i,
  input  logic [1:0]  ld_size_i,
  input  logic        ld_un_sign_i,
  output logic [31:0] ld_data_o
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Store data is replicated across all lanes so the byte enables alone pick the target.
  always_comb begin
    be_o    = 4'hF;
    wdata_o = 32'h0;
    if (we_i) begin
      case (size_i)
        SB_BYTE: begin
          be_o    = 4'b0001 << off_i;
          wdata_o = {4{wdata_i[7:0]}};
        end
        SB_HALF: begin
          be_o    = off_i[1] ? 4'b1100 : 4'b0011;
          wdata_o = {2{wdata_i[15:0]}};
        end
        default: wdata_o = wdata_i;
      endcase
    end
  end

  always_comb begin
    ld_byte = ld_word_i[{ld_off_i, 3'b000} +: 8];
    ld_half = ld_word_i[{ld_off_i[1], 4'b0000} +: 16];
    case (ld_size_i)
      SB_BYTE: ld_data_o = {{24{~ld_un_sign_i & ld_byte[7]}}, ld_byte};
      SB_HALF: ld_data_o = {{16{~ld_un_sign_i & ld_half[15]}}, ld_half};
      default: ld_data_o = ld_word_i;
    endcase
  end

endmodule

// File: rtl/sb_arbiter.sv
// Two-master (fetch / load-store) arbiter and sequencer for the single system-bus port.
// Latency: request in cycle N -> bus_req N+1 -> done pulse at earliest N+2, IDLE at N+3.
// Backpressure: waits on bus_gnt / bus_rvalid; hold_o stalls the pipeline while a load/store is open.
// Ports: clk/rst (sync, active-low); if_* fetch side; ls_* load/store side; hold_o stall;
//        bus_* registered address phase plus bus_gnt/bus_rvalid/bus_rdata response; bus_err timeout.
// Optional: define SB_TIMEOUT_EN to abort a transaction after TIMEOUT_CYCLES in REQ+RESP.
module sb_arbiter
  import sb_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        ls_re,
  input  logic        ls_we,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  input  logic [1:0]  ls_byte_sel,
  input  logic        ls_un_sign,
  output logic        ls_done,
  output logic [31:0] ls_rdata,
  output logic        ls_misalign,
  output logic        hold_o,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata,
  output logic        bus_err
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("sb_arbiter: TIMEOUT_CYCLES must be 1..255");
  end

  sb_state_e   state_q, state_d;
  logic        owner_q, owner_d;
  logic [1:0]  off_q, off_d;
  logic [1:0]  size_q, size_d;
  logic        un_sign_q, un_sign_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [3:0]  bus_be_q, bus_be_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;

  logic        ls_req;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [31:0] ld_data;
  logic        tmo_hit;

  assign ls_req = ls_re | ls_we;

  // Store side is fed live so the steered data can be latched on the IDLE->REQ edge;
  // load side works on the latched offset/size while the response is on the bus.
  sb_lane_align u_lane_align (
    .we_i        (ls_we),
    .size_i      (ls_byte_sel),
    .off_i       (ls_addr[1:0]),
    .wdata_i     (ls_wdata),
    .be_o        (st_be),
    .wdata_o     (st_wdata),
    .ld_word_i   (bus_rdata),
    .ld_off_i    (off_q),
    .ld_size_i   (size_q),
    .ld_un_sign_i(un_sign_q),
    .ld_data_o   (ld_data)
  );

`ifdef SB_TIMEOUT_EN
  localparam logic [7:0] TMO_LIM = 8'(TIMEOUT_CYCLES);
  logic [7:0] cnt_q, cnt_d;

  // A response arriving in the limit cycle still counts as completion.
  assign tmo_hit = (state_q == REQ || (state_q == RESP && !bus_rvalid)) && (cnt_q == TMO_LIM);

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE && state_d == REQ) cnt_d = 8'd0;
    else if (state_q == REQ || state_q == RESP) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= 8'd0;
    else      cnt_q <= cnt_d;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    off_d       = off_q;
    size_d      = size_q;
    un_sign_d   = un_sign_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_be_d    = bus_be_q;
    bus_wdata_d = bus_wdata_q;
    ls_done     = 1'b0;
    ls_misalign = 1'b0;
    ls_rdata    = 32'h0;
    if_rvalid   = 1'b0;
    if_rdata    = 32'h0;
    bus_err     = 1'b0;

    case (state_q)
      IDLE: begin
        if (ls_req) begin
          if (sb_misaligned(ls_byte_sel, ls_addr[1:0])) begin
            // Rejected without a bus cycle; completes in the same cycle.
            ls_done     = 1'b1;
            ls_misalign = 1'b1;
          end else begin
            state_d     = REQ;
            owner_d     = OWN_LS;
            bus_req_d   = 1'b1;
            bus_we_d    = ls_we;
            bus_addr_d  = ls_addr & 32'hFFFF_FFFC;
            bus_be_d    = st_be;
            bus_wdata_d = st_wdata;
            off_d       = ls_addr[1:0];
            size_d      = ls_byte_sel;
            un_sign_d   = ls_un_sign;
          end
        end else if (if_req) begin
          state_d     = REQ;
          owner_d     = OWN_IF;
          bus_req_d   = 1'b1;
          bus_we_d    = 1'b0;
          bus_addr_d  = if_addr & 32'hFFFF_FFFC;
          bus_be_d    = 4'hF;
          bus_wdata_d = 32'h0;
          off_d       = 2'b00;
          size_d      = SB_WORD;
          un_sign_d   = SB_SIGNED;
        end
      end
      REQ: begin
        if (bus_gnt) begin
          state_d   = RESP;
          bus_req_d = 1'b0;
        end
      end
      RESP: begin
        if (bus_rvalid) begin
          state_d = IDLE;
          if (owner_q == OWN_LS) begin
            ls_done  = 1'b1;
            ls_rdata = ld_data;
          end else begin
            if_rvalid = 1'b1;
            if_rdata  = bus_rdata;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Abort: owner sees a completion with zero data.
    if (tmo_hit) begin
      state_d   = IDLE;
      bus_req_d = 1'b0;
      bus_err   = 1'b1;
      if (owner_q == OWN_LS) ls_done = 1'b1;
      else                   if_rvalid = 1'b1;
    end

    // Completion pulses are suppressed while reset is held, so a response landing
    // in the reset cycle is never reported.
    if (!rst) begin
      ls_done     = 1'b0;
      ls_misalign = 1'b0;
      ls_rdata    = 32'h0;
      if_rvalid   = 1'b0;
      if_rdata    = 32'h0;
      bus_err     = 1'b0;
    end
  end

  assign hold_o    = ls_req & ~ls_done;
  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_be    = bus_be_q;
  assign bus_wdata = bus_wdata_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      owner_q     <= OWN_IF;
      off_q       <= 2'b00;
      size_q      <= 2'b00;
      un_sign_q   <= 1'b0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 32'h0;
      bus_be_q    <= 4'h0;
      bus_wdata_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      off_q       <= off_d;
      size_q      <= size_d;
      un_sign_q   <= un_sign_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_be_q    <= bus_be_d;
      bus_wdata_q <= bus_wdata_d;
    end
  end

endmodule

// File: tb/tb_sb_arbiter.sv
// Self-checking bench for sb_arbiter: directed cases plus randomized load/store/fetch traffic
// checked against an arithmetic reference model of lane steering and extension.
module tb_sb_arbiter;
  import sb_arbiter_pkg::*;

`ifdef SB_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 255;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        ls_re = 1'b0, ls_we = 1'b0;
  logic [31:0] ls_addr = '0, ls_wdata = '0;
  logic [1:0]  ls_byte_sel = '0;
  logic        ls_un_sign = 1'b0;
  logic        ls_done, ls_misalign, hold_o;
  logic [31:0] ls_rdata;
  logic        bus_req, bus_we, bus_err;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_gnt = 1'b0, bus_rvalid = 1'b0;
  logic [31:0] bus_rdata = '0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  sb_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_re(ls_re), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_byte_sel(ls_byte_sel), .ls_un_sign(ls_un_sign), .ls_done(ls_done),
    .ls_rdata(ls_rdata), .ls_misalign(ls_misalign), .hold_o(hold_o),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid),
    .bus_rdata(bus_rdata), .bus_err(bus_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit m_misal(input logic [1:0] size, input logic [31:0] addr);
    if (size == SB_HALF) return (addr % 2) != 0;
    if (size == SB_WORD) return (addr % 4) != 0;
    return 1'b0;
  endfunction

  function automatic logic [3:0] m_be(input bit we, input logic [1:0] size, input logic [31:0] addr);
    int off = addr % 4;
    if (!we || size == SB_WORD) return 4'hF;
    if (size == SB_BYTE) return 4'(1 << off);
    return (off >= 2) ? 4'hC : 4'h3;
  endfunction

  function automatic logic [31:0] m_wdata(input bit we, input logic [1:0] size, input logic [31:0] wd);
    logic [31:0] b = wd % 256;
    logic [31:0] h = wd % 65536;
    if (!we) return 32'h0;
    if (size == SB_BYTE) return b * 32'h0101_0101;
    if (size == SB_HALF) return h * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] m_rdata(input logic [31:0] word, input logic [31:0] addr,
                                          input logic [1:0] size, input bit uns);
    logic [31:0] v;
    int off = addr % 4;
    if (size == SB_BYTE) begin
      v = (word >> (8 * off)) % 256;
      if (!uns && v >= 128) v = v - 256;
    end else if (size == SB_HALF) begin
      v = (word >> (8 * off)) % 65536;
      if (!uns && v >= 32768) v = v - 65536;
    end else begin
      v = word;
    end
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One load/store from an idle arbiter; entered and left at a negedge.
  task automatic ls_txn(input bit re, input bit we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [1:0] size, input bit uns, input logic [31:0] rd,
                        input int gd, input int rdly);
    ls_re = re; ls_we = we; ls_addr = addr; ls_wdata = wd; ls_byte_sel = size; ls_un_sign = uns;
    #1;
    if (m_misal(size, addr)) begin
      chk("mis_done", ls_done, 1);
      chk("mis_flag", ls_misalign, 1);
      chk("mis_hold", hold_o, 0);
      tick();
      chk("mis_noreq", bus_req, 0);
      ls_re = 0; ls_we = 0;
      return;
    end
    chk("hold_start", hold_o, 1);
    chk("done_early", ls_done, 0);
    tick();
    chk("req", bus_req, 1);
    chk("we", bus_we, we);
    chk("addr", bus_addr, addr & 32'hFFFF_FFFC);
    chk("be", bus_be, m_be(we, size, addr));
    chk("wdata", bus_wdata, m_wdata(we, size, wd));
    for (int i = 0; i < gd; i++) begin
      bus_rvalid = 1'b1;  // stray response before grant must be ignored
      bus_rdata  = 32'hDEAD_BEEF;
      #1;
      chk("stray_rv", ls_done, 0);
      tick();
      bus_rvalid = 1'b0;
      chk("req_stable", bus_req, 1);
      chk("be_stable", bus_be, m_be(we, size, addr));
      chk("wd_stable", bus_wdata, m_wdata(we, size, wd));
      chk("hold_req", hold_o, 1);
    end
    bus_gnt = 1'b1;
    tick();
    bus_gnt = 1'b0;
    chk("req_drop", bus_req, 0);
    for (int i = 0; i < rdly; i++) begin
      tick();
      chk("resp_wait", ls_done, 0);
    end
    bus_rvalid = 1'b1; bus_rdata = rd;
    #1;
    chk("done", ls_done, 1);
    chk("done_mis", ls_misalign, 0);
    chk("done_hold", hold_o, 0);
    chk("done_if", if_rvalid, 0);
    if (!we) chk("rdata", ls_rdata, m_rdata(rd, addr, size, uns));
    tick();
    bus_rvalid = 1'b0; ls_re = 0; ls_we = 0;
    #1;
    chk("after_done", ls_done, 0);
    chk("after_req", bus_req, 0);
  endtask

  task automatic if_txn(input logic [31:0] addr, input logic [31:0] rd, input int gd, input int rdly);
    if_req = 1'b1; if_addr = addr;
    tick();
    chk("if_req", bus_req, 1);
    chk("if_we", bus_we, 0);
    chk("if_addr", bus_addr, addr);
    chk("if_be", bus_be, 4'hF);
    for (int i = 0; i < gd; i++) tick();
    bus_gnt = 1'b1;
    tick();
    bus_gnt = 1'b0;
    for (int i = 0; i < rdly; i++) begin
      tick();
      chk("if_wait", if_rvalid, 0);
    end
    bus_rvalid = 1'b1; bus_rdata = rd;
    #1;
    chk("if_rvalid", if_rvalid, 1);
    chk("if_rdata", if_rdata, rd);
    chk("if_lsdone", ls_done, 0);
    tick();
    bus_rvalid = 1'b0; if_req = 1'b0;
    #1;
    chk("if_after", if_rvalid, 0);
  endtask

  initial begin
    // ---- reset state ----
    ls_re = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req", bus_req, 0);
    chk("rst_addr", bus_addr, 0);
    chk("rst_be", bus_be, 0);
    chk("rst_done", ls_done, 0);
    chk("rst_ifv", if_rvalid, 0);
    chk("rst_err", bus_err, 0);
    chk("rst_hold", hold_o, 1);
    ls_re = 1'b0;
    #1;
    chk("rst_hold0", hold_o, 0);
    rst = 1'b1;
    tick();

    // ---- directed load-byte extension ----
    ls_txn(1, 0, 32'h1003, 0, SB_BYTE, SB_SIGNED,   32'h8000_0000, 0, 0);
    ls_txn(1, 0, 32'h1003, 0, SB_BYTE, SB_UNSIGNED, 32'h8000_0000, 0, 0);
    ls_txn(1, 0, 32'h1002, 0, SB_HALF, SB_SIGNED,   32'h9ABC_1234, 0, 1);
    // ---- store half, grant delayed 3 cycles ----
    ls_txn(0, 1, 32'h2002, 32'h1234_ABCD, SB_HALF, 0, 0, 3, 0);
    // ---- misaligned word ----
    ls_txn(1, 0, 32'h3002, 0, SB_WORD, 0, 0, 0, 0);
    // ---- both load and store set: store wins ----
    ls_txn(1, 1, 32'h4001, 32'h0000_00A5, SB_BYTE, 0, 0, 0, 0);

    // ---- simultaneous fetch and load: LS first, then IF ----
    if_req = 1'b1; if_addr = 32'h400;
    ls_re = 1'b1; ls_addr = 32'h104; ls_byte_sel = SB_WORD; ls_un_sign = 0; ls_we = 0;
    tick();
    chk("both_addr_ls", bus_addr, 32'h104);
    bus_gnt = 1'b1; tick(); bus_gnt = 1'b0;
    bus_rvalid = 1'b1; bus_rdata = 32'h1122_3344;
    #1;
    chk("both_lsdone", ls_done, 1);
    chk("both_lsdata", ls_rdata, 32'h1122_3344);
    chk("both_noif", if_rvalid, 0);
    tick();
    bus_rvalid = 1'b0; ls_re = 1'b0;
    #1;
    chk("both_gap_ls", ls_done, 0);
    chk("both_gap_if", if_rvalid, 0);
    if_txn(32'h400, 32'hCAFE_F00D, 0, 0);

    // ---- reset in RESP, late response ignored ----
    ls_re = 1'b1; ls_addr = 32'h500; ls_byte_sel = SB_WORD;
    tick();
    bus_gnt = 1'b1; tick(); bus_gnt = 1'b0;
    rst = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h5555_AAAA;
    #1;
    chk("rst_resp_done", ls_done, 0);
    tick();
    rst = 1'b1; ls_re = 1'b0;
    #1;
    chk("rst_late_done", ls_done, 0);
    chk("rst_late_ifv", if_rvalid, 0);
    chk("rst_late_req", bus_req, 0);
    tick();
    bus_rvalid = 1'b0;
    chk("rst_idle_req", bus_req, 0);

`ifdef SB_TIMEOUT_EN
    // ---- timeout: grant never comes ----
    ls_re = 1'b1; ls_addr = 32'h600; ls_byte_sel = SB_WORD;
    tick();
    chk("to_req", bus_req, 1);
    for (int k = 1; k < TO; k++) begin
      tick();
      chk("to_early_err", bus_err, 0);
      chk("to_early_done", ls_done, 0);
    end
    tick();
    chk("to_err", bus_err, 1);
    chk("to_done", ls_done, 1);
    chk("to_rdata", ls_rdata, 0);
    tick();
    ls_re = 1'b0;
    #1;
    chk("to_req_drop", bus_req, 0);
    chk("to_err_drop", bus_err, 0);
`endif

    // ---- randomized traffic ----
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(3) == 0) begin
        if_txn($urandom & 32'hFFFF_FFFC, $urandom, $urandom_range(1), $urandom_range(1));
      end else begin
        bit we = $urandom_range(1) == 1;
        bit re = we ? ($urandom_range(1) == 1) : 1'b1;
        ls_txn(re, we, $urandom, $urandom, 2'($urandom_range(2)), $urandom_range(1) == 1,
               $urandom, $urandom_range(1), $urandom_range(1));
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
